pci_target_mem: RTL and testbench
=================================

PCI_TARGET_MEM -- requirements
Module: pci_target_mem

Interface
REQ-001 Parameters SHALL be, one per line:
- BASE_ADDR, 32'h0000_0010, byte address of memory word 0; 4-byte aligned.
- DEPTH, 4, number of 32-bit words; power of 2, range 4..256.
- WAIT_STATES, 0, extra cycles before each trdy_n assertion; range 0..3.
REQ-002 Reset SHALL be RST, synchronous, active-high; the clock SHALL be CLK.
REQ-003 Ports SHALL be, one per line (name, direction, width, meaning):
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  synchronous active-high reset.
- frame_n  in  1  PCI FRAME#, active low.
- irdy_n  in  1  PCI IRDY#, active low.
- cbe_n  in  4  command during the address phase; byte enables (active low) during data phases.
- ad_in  in  32  AD bus as sampled.
- ad_out  out  32  read data to drive onto AD.
- ad_oe  out  1  AD output enable.
- devsel_n  out  1  DEVSEL#, active low.
- trdy_n  out  1  TRDY#, active low.
- stop_n  out  1  STOP#, active low.
- busy  out  1  high while the target owns the transaction.
- xfer_count  out  9  number of data transfers completed in the current transaction.

Function
REQ-004 Address phase SHALL be the rising edge where the FSM is IDLE and frame_n=0; ad_in and cbe_n are captured on that edge.
REQ-005 Accepted commands SHALL be 0010 I/O read, 0011 I/O write, 0110 memory read and 0111 memory write; any other command is ignored.
REQ-006 Hit SHALL be: command accepted, BASE_ADDR <= ad_in < BASE_ADDR+4*DEPTH, and ad_in[1:0]=00.
- On a miss, the FSM stays IDLE and all outputs stay deasserted until frame_n=1 and irdy_n=1.
REQ-007 Start index SHALL be (ad_in-BASE_ADDR)>>2.
REQ-008 FSM states SHALL be IDLE, CLAIM, TAR, WAIT, XFER, STOP, DONE.
REQ-009 On a hit, the FSM SHALL enter CLAIM and assert devsel_n=0 in the cycle following the address phase (medium decode).
REQ-010 Write timing: trdy_n SHALL go low 1+WAIT_STATES cycles after the address phase.
REQ-011 Read timing:
- ad_oe=1 from cycle 2 (TAR occupies cycle 1).
- trdy_n SHALL go low 2+WAIT_STATES cycles after the address phase.
- ad_out SHALL hold mem[index] whenever trdy_n=0.
REQ-012 A data transfer SHALL occur on every edge with irdy_n=0 and trdy_n=0; nothing transfers on any other edge.
REQ-013 On a transfer:
- index increments by 1.
- xfer_count increments by 1.
- For writes, only byte lanes with cbe_n[i]=0 are updated; cbe_n=1111 writes nothing but still advances index.
REQ-014 With WAIT_STATES=0, trdy_n SHALL stay low across consecutive transfers (one word per cycle).
- With WAIT_STATES>0, trdy_n SHALL rise for WAIT_STATES cycles after each transfer.
REQ-015 Master wait (irdy_n=1 while trdy_n=0): the target SHALL hold trdy_n, ad_out and index unchanged.
REQ-016 Normal completion: on a transfer with frame_n=1, the FSM SHALL enter DONE.
- Next cycle: devsel_n=1, trdy_n=1, ad_oe=0.
- FSM returns to IDLE.
REQ-017 Disconnect at end of memory: on the transfer to index DEPTH-1 with frame_n=0, the target SHALL assert stop_n=0 on the same edge its trdy_n for that word is low (disconnect-with-data).
- The FSM enters STOP and keeps trdy_n=1 with stop_n=0 and devsel_n=0 until frame_n is sampled 1.
- The FSM then deasserts all outputs and returns to IDLE; index SHALL never wrap.
REQ-018 busy SHALL be 1 in every state except IDLE.
REQ-019 xfer_count SHALL clear on entry to CLAIM.
REQ-020 Memory reads SHALL be combinational from the array; memory contents are not affected by RST.

Reset
REQ-021 While RST=1 at an edge, the block SHALL force:
- FSM=IDLE, devsel_n=1, trdy_n=1, stop_n=1, ad_oe=0.
- ad_out=0, busy=0, xfer_count=0, index=0.
REQ-022 RST asserted mid-transaction SHALL abort immediately, with no memory write on that edge.
- After RST releases, a new address phase is required only once frame_n is sampled 1.

Verification
REQ-023 Single write: 0111 to 0x10, data 0xA5A5_1234, cbe_n=0000, frame_n high with irdy_n -> devsel_n low at cycle 1, trdy_n low at cycle 1, mem[0]=0xA5A5_1234, DONE then IDLE.
REQ-024 Burst read with WAIT_STATES=0: 0010 at 0x10, 3 transfers -> ad_oe from cycle 2, ad_out=mem[0],mem[1],mem[2] on consecutive edges, xfer_count=3.
REQ-025 Byte enables: write 0xFFFF_FFFF with cbe_n=1010 to a word holding 0 -> word=0x00FF_00FF.
REQ-026 End-of-memory burst at DEPTH=4: write starting at 0x18 (index 2), master keeps frame_n low -> two transfers, stop_n low with trdy_n on index 3, no wrap, stop_n held until frame_n=1.
REQ-027 Miss and wait states: 0011 to 0x40 -> devsel_n stays 1, memory unchanged; WAIT_STATES=2 read with irdy_n high for 1 cycle -> trdy_n at cycle 4, data held until irdy_n low.
REQ-028 RST pulse during the second word of a burst write -> all outputs at reset values next edge, second word not written.

Source files
------------

// File: rtl/pci_target_mem.sv
// pci_target_mem: PCI target with a small 32-bit word memory behind it.
// Claims I/O and memory read/write cycles that decode into the window
// [BASE_ADDR, BASE_ADDR + 4*DEPTH). It uses medium decode timing and
// optional wait states. A burst that runs off the last word is ended with
// a disconnect-with-data.
//
// Ports
//   CLK, RST     clock; synchronous active-high reset
//   frame_n      FRAME#, active low
//   irdy_n       IRDY#, active low
//   cbe_n[3:0]   command (address phase) / byte enables, active low (data)
//   ad_in[31:0]  sampled AD bus
//   ad_out[31:0] read data, valid while trdy_n=0
//   ad_oe        AD output enable (reads only, after turnaround)
//   devsel_n     DEVSEL#, active low
//   trdy_n       TRDY#, active low
//   stop_n       STOP#, active low
//   busy         target owns the current transaction
//   xfer_count   data transfers completed in the current transaction
module pci_target_mem #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0010,
  parameter int          DEPTH       = 4,
  parameter int          WAIT_STATES = 0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        frame_n,
  input  logic        irdy_n,
  input  logic [3:0]  cbe_n,
  input  logic [31:0] ad_in,
  output logic [31:0] ad_out,
  output logic        ad_oe,
  output logic        devsel_n,
  output logic        trdy_n,
  output logic        stop_n,
  output logic        busy,
  output logic [8:0]  xfer_count
);

  localparam int          IW       = $clog2(DEPTH);
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(4 * DEPTH);
  localparam logic [1:0]  WS       = 2'(WAIT_STATES);
  localparam logic [IW-1:0] LAST   = IW'(DEPTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_CLAIM, S_TAR, S_WAIT, S_XFER, S_STOP, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   index_q, index_d;
  logic [8:0]      xfer_count_q, xfer_count_d;
  logic [1:0]      wait_q, wait_d;
  logic            devsel_n_q, devsel_n_d;
  logic            trdy_n_q, trdy_n_d;
  logic            ad_oe_q, ad_oe_d;
  logic            is_read_q, is_read_d;
  logic            ignore_q, ignore_d;
  logic            mem_we;
  logic [31:0]     mem_q [DEPTH];

  logic            cmd_ok;
  logic            hit;
  logic [IW-1:0]   start_idx;

  always_comb begin
    cmd_ok = 1'b0;
    case (cbe_n)
      4'b0010, 4'b0011, 4'b0110, 4'b0111: cmd_ok = 1'b1;
      default:                             cmd_ok = 1'b0;
    endcase
  end

  assign hit = cmd_ok && ({1'b0, ad_in} >= {1'b0, BASE_ADDR}) &&
               ({1'b0, ad_in} < END_ADDR) && (ad_in[1:0] == 2'b00);
  assign start_idx = IW'((ad_in - BASE_ADDR) >> 2);

  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    xfer_count_d = xfer_count_q;
    wait_d       = wait_q;
    devsel_n_d   = devsel_n_q;
    trdy_n_d     = trdy_n_q;
    ad_oe_d      = ad_oe_q;
    is_read_d    = is_read_q;
    ignore_d     = ignore_q;
    mem_we       = 1'b0;
    case (state_q)
      S_IDLE: begin
        // ignore_q: a transaction we do not own (a miss, or one cut by reset)
        // is still on the bus; wait for the bus to go idle first.
        if (ignore_q) begin
          if (frame_n && irdy_n) ignore_d = 1'b0;
        end else if (!frame_n) begin
          if (hit) begin
            state_d      = S_CLAIM;
            devsel_n_d   = 1'b0;
            index_d      = start_idx;
            xfer_count_d = '0;
            is_read_d    = ~cbe_n[0];
            if (~cbe_n[0])             wait_d   = WS;
            else if (WAIT_STATES == 0) trdy_n_d = 1'b0;
            else                       wait_d   = WS - 2'd1;
          end else begin
            ignore_d = 1'b1;
          end
        end
      end
      S_CLAIM, S_TAR, S_WAIT, S_XFER: begin
        // CLAIM doubles as the read turnaround cycle.
        if (state_q == S_CLAIM) ad_oe_d = is_read_q;
        if (!trdy_n_q) begin
          if (!irdy_n) begin
            mem_we       = !is_read_q;
            xfer_count_d = xfer_count_q + 9'd1;
            if (frame_n) begin
              state_d    = S_DONE;
              devsel_n_d = 1'b1;
              trdy_n_d   = 1'b1;
              ad_oe_d    = 1'b0;
            end else if (index_q == LAST) begin
              state_d  = S_STOP;
              trdy_n_d = 1'b1;
            end else begin
              index_d = index_q + IW'(1);
              if (WAIT_STATES == 0) begin
                state_d = S_XFER;
              end else begin
                state_d  = S_WAIT;
                trdy_n_d = 1'b1;
                wait_d   = WS - 2'd1;
              end
            end
          end
        end else if (wait_q == 2'd0) begin
          state_d  = S_XFER;
          trdy_n_d = 1'b0;
        end else begin
          wait_d = wait_q - 2'd1;
          if (state_q == S_CLAIM) state_d = is_read_q ? S_TAR : S_WAIT;
        end
      end
      S_STOP: begin
        if (frame_n) begin
          state_d    = S_IDLE;
          devsel_n_d = 1'b1;
          ad_oe_d    = 1'b0;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      index_q      <= '0;
      xfer_count_q <= '0;
      wait_q       <= '0;
      devsel_n_q   <= 1'b1;
      trdy_n_q     <= 1'b1;
      ad_oe_q      <= 1'b0;
      is_read_q    <= 1'b0;
      ignore_q     <= 1'b1;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      xfer_count_q <= xfer_count_d;
      wait_q       <= wait_d;
      devsel_n_q   <= devsel_n_d;
      trdy_n_q     <= trdy_n_d;
      ad_oe_q      <= ad_oe_d;
      is_read_q    <= is_read_d;
      ignore_q     <= ignore_d;
    end
  end

  // Memory array has no reset; RST only blocks the write on its edge.
  always_ff @(posedge CLK) begin
    if (!RST && mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (!cbe_n[b]) mem_q[index_q][8*b +: 8] <= ad_in[8*b +: 8];
      end
    end
  end

  // STOP# on the last word must coincide with its TRDY#, and depends on
  // whether the master is still asking for more (frame_n low).
  assign stop_n     = !((state_q == S_STOP) ||
                        (!trdy_n_q && (index_q == LAST) && !frame_n));
  assign ad_out     = trdy_n_q ? 32'h0 : mem_q[index_q];
  assign ad_oe      = ad_oe_q;
  assign devsel_n   = devsel_n_q;
  assign trdy_n     = trdy_n_q;
  assign busy       = (state_q != S_IDLE);
  assign xfer_count = xfer_count_q;

endmodule

// File: tb/tb_pci_target_mem.sv
// tb_pci_target_mem: directed bench for pci_target_mem.
// Two instances share the bus drivers. u_ws0 uses WAIT_STATES=0 and
// u_ws2 uses WAIT_STATES=2. Only the instance picked by sel sees an
// active bus; the other one sees an idle bus.
module tb_pci_target_mem;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        frame_n = 1'b1;
  logic        irdy_n = 1'b1;
  logic [3:0]  cbe_n = 4'hF;
  logic [31:0] ad_in = 32'h0;
  logic        sel = 1'b0;

  always #5 CLK = ~CLK;

  logic        f0, f1, i0, i1;
  logic [31:0] ad_out0, ad_out1, ad_out;
  logic        ad_oe0, ad_oe1, ad_oe;
  logic        devsel_n0, devsel_n1, devsel_n;
  logic        trdy_n0, trdy_n1, trdy_n;
  logic        stop_n0, stop_n1, stop_n;
  logic        busy0, busy1, busy;
  logic [8:0]  xc0, xc1, xfer_count;

  assign f0 = sel ? 1'b1 : frame_n;
  assign i0 = sel ? 1'b1 : irdy_n;
  assign f1 = sel ? frame_n : 1'b1;
  assign i1 = sel ? irdy_n : 1'b1;

  assign ad_out     = sel ? ad_out1 : ad_out0;
  assign ad_oe      = sel ? ad_oe1 : ad_oe0;
  assign devsel_n   = sel ? devsel_n1 : devsel_n0;
  assign trdy_n     = sel ? trdy_n1 : trdy_n0;
  assign stop_n     = sel ? stop_n1 : stop_n0;
  assign busy       = sel ? busy1 : busy0;
  assign xfer_count = sel ? xc1 : xc0;

  pci_target_mem #(.BASE_ADDR(32'h10), .DEPTH(4), .WAIT_STATES(0)) u_ws0 (
    .CLK(CLK), .RST(RST), .frame_n(f0), .irdy_n(i0), .cbe_n(cbe_n), .ad_in(ad_in),
    .ad_out(ad_out0), .ad_oe(ad_oe0), .devsel_n(devsel_n0), .trdy_n(trdy_n0),
    .stop_n(stop_n0), .busy(busy0), .xfer_count(xc0));

  pci_target_mem #(.BASE_ADDR(32'h10), .DEPTH(4), .WAIT_STATES(2)) u_ws2 (
    .CLK(CLK), .RST(RST), .frame_n(f1), .irdy_n(i1), .cbe_n(cbe_n), .ad_in(ad_in),
    .ad_out(ad_out1), .ad_oe(ad_oe1), .devsel_n(devsel_n1), .trdy_n(trdy_n1),
    .stop_n(stop_n1), .busy(busy1), .xfer_count(xc1));

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic addr_phase(input logic [3:0] cmd, input logic [31:0] a);
    frame_n = 1'b0; irdy_n = 1'b1; cbe_n = cmd; ad_in = a;
    tick();
  endtask

  task automatic bus_idle();
    frame_n = 1'b1; irdy_n = 1'b1; cbe_n = 4'hF; ad_in = 32'h0;
    tick();
  endtask

  task automatic wait_trdy(input string tag);
    for (int i = 0; i < 8; i++) begin
      if (trdy_n === 1'b0) break;
      tick();
    end
    check(tag, {31'h0, trdy_n}, 32'h0);
  endtask

  task automatic wr1(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    addr_phase(4'b0111, a);
    frame_n = 1'b1; irdy_n = 1'b0; cbe_n = be; ad_in = d;
    wait_trdy("wr1_trdy");
    tick();
    bus_idle();
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr_phase(4'b0110, a);
    frame_n = 1'b1; irdy_n = 1'b0; cbe_n = 4'h0; ad_in = 32'h0;
    wait_trdy("rd1_trdy");
    check(tag, ad_out, exp);
    tick();
    bus_idle();
  endtask

  task automatic miss_wr(input string tag, input logic [3:0] cmd, input logic [31:0] a);
    addr_phase(cmd, a);
    check(tag, {31'h0, devsel_n}, 32'h1);
    frame_n = 1'b1; irdy_n = 1'b0; cbe_n = 4'h0; ad_in = 32'hDEAD_BEEF;
    tick();
    check(tag, {30'h0, devsel_n, trdy_n}, 32'h3);
    bus_idle();
  endtask

  task automatic chk_reset_outputs(input string tag);
    check({tag, "_devsel"}, {31'h0, devsel_n}, 32'h1);
    check({tag, "_trdy"},   {31'h0, trdy_n},   32'h1);
    check({tag, "_stop"},   {31'h0, stop_n},   32'h1);
    check({tag, "_adoe"},   {31'h0, ad_oe},    32'h0);
    check({tag, "_adout"},  ad_out,            32'h0);
    check({tag, "_busy"},   {31'h0, busy},     32'h0);
    check({tag, "_xc"},     {23'h0, xfer_count}, 32'h0);
  endtask

  initial begin
    RST = 1'b1;
    tick(); tick();
    chk_reset_outputs("rst");
    RST = 1'b0;
    bus_idle();

    // Single write to word 0, WAIT_STATES=0.
    addr_phase(4'b0111, 32'h10);
    check("sw_devsel", {31'h0, devsel_n}, 32'h0);
    check("sw_trdy",   {31'h0, trdy_n},   32'h0);
    check("sw_busy",   {31'h0, busy},     32'h1);
    frame_n = 1'b1; irdy_n = 1'b0; cbe_n = 4'h0; ad_in = 32'hA5A5_1234;
    tick();
    check("sw_done_devsel", {31'h0, devsel_n}, 32'h1);
    check("sw_done_trdy",   {31'h0, trdy_n},   32'h1);
    check("sw_done_busy",   {31'h0, busy},     32'h1);
    check("sw_done_xc",     {23'h0, xfer_count}, 32'h1);
    bus_idle();
    check("sw_idle_busy", {31'h0, busy}, 32'h0);

    // Two-word write burst at word 1.
    addr_phase(4'b0111, 32'h14);
    frame_n = 1'b0; irdy_n = 1'b0; cbe_n = 4'h0; ad_in = 32'h2222_2222;
    tick();
    frame_n = 1'b1; ad_in = 32'h3333_3333;
    #1 check("wb_stop", {31'h0, stop_n}, 32'h1);
    tick();
    check("wb_xc", {23'h0, xfer_count}, 32'h2);
    bus_idle();

    // Three-word I/O read burst from word 0.
    addr_phase(4'b0010, 32'h10);
    check("rb_c1_adoe", {31'h0, ad_oe},    32'h0);
    check("rb_c1_trdy", {31'h0, trdy_n},   32'h1);
    check("rb_c1_dev",  {31'h0, devsel_n}, 32'h0);
    frame_n = 1'b0; irdy_n = 1'b0; cbe_n = 4'h0; ad_in = 32'h0;
    tick();
    check("rb_c2_adoe", {31'h0, ad_oe},  32'h1);
    check("rb_c2_trdy", {31'h0, trdy_n}, 32'h0);
    check("rb_d0", ad_out, 32'hA5A5_1234);
    tick();
    check("rb_d1", ad_out, 32'h2222_2222);
    check("rb_c3_trdy", {31'h0, trdy_n}, 32'h0);
    tick();
    check("rb_d2", ad_out, 32'h3333_3333);
    frame_n = 1'b1;
    tick();
    check("rb_xc",   {23'h0, xfer_count}, 32'h3);
    check("rb_adoe", {31'h0, ad_oe},      32'h0);
    check("rb_trdy", {31'h0, trdy_n},     32'h1);
    bus_idle();

    // Byte enables on word 3.
    wr1(32'h1C, 32'h0, 4'h0);
    wr1(32'h1C, 32'hFFFF_FFFF, 4'b1010);
    rd_chk("be_word", 32'h1C, 32'h00FF_00FF);

    // End-of-memory burst from word 2 with frame_n held low.
    addr_phase(4'b0111, 32'h18);
    frame_n = 1'b0; irdy_n = 1'b0; cbe_n = 4'h0; ad_in = 32'hAAAA_0002;
    #1 check("eom_stop_w2", {31'h0, stop_n}, 32'h1);
    tick();
    ad_in = 32'hBBBB_0003;
    #1 check("eom_stop_w3", {31'h0, stop_n}, 32'h0);
    check("eom_trdy_w3", {31'h0, trdy_n}, 32'h0);
    tick();
    check("eom_s_trdy", {31'h0, trdy_n},   32'h1);
    check("eom_s_stop", {31'h0, stop_n},   32'h0);
    check("eom_s_dev",  {31'h0, devsel_n}, 32'h0);
    check("eom_s_xc",   {23'h0, xfer_count}, 32'h2);
    irdy_n = 1'b1;
    tick();
    check("eom_hold_stop", {31'h0, stop_n}, 32'h0);
    frame_n = 1'b1;
    tick();
    check("eom_end", {29'h0, stop_n, devsel_n, busy}, 32'h6);
    bus_idle();
    rd_chk("eom_w2", 32'h18, 32'hAAAA_0002);
    rd_chk("eom_w3", 32'h1C, 32'hBBBB_0003);
    rd_chk("eom_nowrap", 32'h10, 32'hA5A5_1234);

    // Misses: out of range, one past the end, misaligned, unsupported command.
    miss_wr("miss_40", 4'b0011, 32'h40);
    miss_wr("miss_20", 4'b0111, 32'h20);
    miss_wr("miss_11", 4'b0111, 32'h11);
    miss_wr("miss_cmd", 4'b0100, 32'h10);
    rd_chk("miss_w0", 32'h10, 32'hA5A5_1234);
    rd_chk("miss_w3", 32'h1C, 32'hBBBB_0003);

    // Reset during the second word of a write burst.
    addr_phase(4'b0111, 32'h10);
    frame_n = 1'b0; irdy_n = 1'b0; cbe_n = 4'h0; ad_in = 32'h5555_0000;
    tick();
    ad_in = 32'h6666_0001; RST = 1'b1;
    tick();
    chk_reset_outputs("midrst");
    RST = 1'b0; cbe_n = 4'b0111; ad_in = 32'h14;
    tick();
    check("postrst_dev", {31'h0, devsel_n}, 32'h1);
    bus_idle();
    rd_chk("rst_w1", 32'h14, 32'h2222_2222);
    rd_chk("rst_w0", 32'h10, 32'h5555_0000);

    // WAIT_STATES=2 instance.
    sel = 1'b1;
    bus_idle();
    addr_phase(4'b0111, 32'h10);
    check("ws2_w_c1", {30'h0, devsel_n, trdy_n}, 32'h1);
    frame_n = 1'b1; irdy_n = 1'b0; cbe_n = 4'h0; ad_in = 32'h0BAD_F00D;
    tick();
    check("ws2_w_c2", {31'h0, trdy_n}, 32'h1);
    tick();
    check("ws2_w_c3", {31'h0, trdy_n}, 32'h0);
    tick();
    check("ws2_w_xc", {23'h0, xfer_count}, 32'h1);
    bus_idle();

    addr_phase(4'b0110, 32'h10);
    check("ws2_r_c1", {30'h0, ad_oe, trdy_n}, 32'h1);
    frame_n = 1'b0; irdy_n = 1'b1; cbe_n = 4'h0; ad_in = 32'h0;
    tick();
    check("ws2_r_c2", {30'h0, ad_oe, trdy_n}, 32'h3);
    tick();
    check("ws2_r_c3", {31'h0, trdy_n}, 32'h1);
    tick();
    check("ws2_r_c4_trdy", {31'h0, trdy_n}, 32'h0);
    check("ws2_r_c4_data", ad_out, 32'h0BAD_F00D);
    tick();
    check("ws2_r_c5_trdy", {31'h0, trdy_n}, 32'h0);
    check("ws2_r_c5_data", ad_out, 32'h0BAD_F00D);
    check("ws2_r_c5_xc", {23'h0, xfer_count}, 32'h0);
    frame_n = 1'b1; irdy_n = 1'b0;
    tick();
    check("ws2_r_done", {22'h0, xfer_count, ad_oe}, 32'h2);
    bus_idle();

    // WAIT_STATES=2 burst: TRDY# drops out for two cycles between words.
    addr_phase(4'b0111, 32'h14);
    frame_n = 1'b0; irdy_n = 1'b0; cbe_n = 4'h0; ad_in = 32'h0000_0001;
    wait_trdy("ws2_b_first");
    tick();
    check("ws2_b_gap1", {31'h0, trdy_n}, 32'h1);
    tick();
    check("ws2_b_gap2", {31'h0, trdy_n}, 32'h1);
    tick();
    check("ws2_b_second", {31'h0, trdy_n}, 32'h0);
    frame_n = 1'b1; ad_in = 32'h0000_0002;
    tick();
    check("ws2_b_xc", {23'h0, xfer_count}, 32'h2);
    bus_idle();
    rd_chk("ws2_b_w2", 32'h18, 32'h0000_0002);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
